// File: rtl/md_hazard_ctrl.sv
// Pipeline stall/flush controller and multiply/divide unit sequencer.
// Compares D-stage Tuse against E/M Tnew, tracks MDU occupancy, counts stall cycles.
module md_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,  // legal range 1..15
    parameter int unsigned DIV_CYCLES  = 10  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        D_rs_use,
    input  logic        D_rt_use,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic        E_we,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_A3,
    input  logic        M_we,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_div_q,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       div_d;
    logic       busy_d;
    logic       done_d;

    logic rs_stall_e, rs_stall_m;
    logic rt_stall_e, rt_stall_m;
    logic data_stall;
    logic md_stall;

    // A source stalls only when its producer delivers later than the consumer needs it;
    // equal timing is covered by the forwarding network.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic       src_use,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic       we,
        input logic [1:0] tnew
    );
        return src_use && (src != 5'd0) && we && (dst == src) && (tuse < tnew);
    endfunction

    assign rs_stall_e = src_hazard(D_rs, D_rs_use, D_rs_tuse, E_A3, E_we, E_tnew);
    assign rs_stall_m = src_hazard(D_rs, D_rs_use, D_rs_tuse, M_A3, M_we, M_tnew);
    assign rt_stall_e = src_hazard(D_rt, D_rt_use, D_rt_tuse, E_A3, E_we, E_tnew);
    assign rt_stall_m = src_hazard(D_rt, D_rt_use, D_rt_tuse, M_A3, M_we, M_tnew);

    assign data_stall = rs_stall_e | rs_stall_m | rt_stall_e | rt_stall_m;
    assign md_stall   = D_is_md & (E_md_start | md_busy);

    assign stall  = data_stall | md_stall;
    assign PC_en  = ~stall;
    assign FD_en  = ~stall;
    assign DE_clr = stall;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = md_div_q;

        if (state_q == IDLE) begin
            if (E_md_start) begin
                state_d = BUSY;
                cnt_d   = E_md_div ? DIV_LOAD : MULT_LOAD;
                div_d   = E_md_div;
            end
        end else begin
            if (cnt_q == 4'd1) begin
                // Last busy cycle may accept the next operation with no idle gap.
                if (E_md_start) begin
                    cnt_d = E_md_div ? DIV_LOAD : MULT_LOAD;
                    div_d = E_md_div;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        busy_d = (state_d == BUSY);
        done_d = (state_d == BUSY) && (cnt_d == 4'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
            md_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_busy  <= busy_d;
            md_done  <= done_d;
            md_div_q <= div_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed bench for md_hazard_ctrl: expectations queued per step, then
// popped and compared against the DUT outputs mid-cycle.
module tb_md_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt;
    logic        D_rs_use, D_rt_use;
    logic [1:0]  D_rs_tuse, D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_A3;
    logic        E_we;
    logic [1:0]  E_tnew;
    logic [4:0]  M_A3;
    logic        M_we;
    logic [1:0]  M_tnew;
    logic        E_md_start, E_md_div;
    logic        stall, PC_en, FD_en, DE_clr;
    logic        md_busy, md_done, md_div_q;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {S_STALL, S_PC_EN, S_FD_EN, S_DE_CLR, S_BUSY, S_DONE, S_DIVQ, S_CNT} sig_e;

    string       tag_q[$];
    sig_e        sig_q[$];
    logic [31:0] exp_q[$];

    md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_use(D_rs_use), .D_rt_use(D_rt_use),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
        .E_A3(E_A3), .E_we(E_we), .E_tnew(E_tnew),
        .M_A3(M_A3), .M_we(M_we), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clr(DE_clr),
        .md_busy(md_busy), .md_done(md_done), .md_div_q(md_div_q),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input string tag, input sig_e s, input logic [31:0] e);
        tag_q.push_back(tag);
        sig_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_stall(input string tag, input logic s);
        push({tag, ".stall"},  S_STALL,  {31'd0, s});
        push({tag, ".PC_en"},  S_PC_EN,  {31'd0, ~s});
        push({tag, ".FD_en"},  S_FD_EN,  {31'd0, ~s});
        push({tag, ".DE_clr"}, S_DE_CLR, {31'd0, s});
    endtask

    task automatic push_md(input string tag, input logic b, input logic d, input logic q);
        push({tag, ".md_busy"},  S_BUSY, {31'd0, b});
        push({tag, ".md_done"},  S_DONE, {31'd0, d});
        push({tag, ".md_div_q"}, S_DIVQ, {31'd0, q});
    endtask

    task automatic drain();
        string       tag;
        sig_e        s;
        logic [31:0] e;
        logic [31:0] obs;
        #1;
        while (tag_q.size() > 0) begin
            tag = tag_q.pop_front();
            s   = sig_q.pop_front();
            e   = exp_q.pop_front();
            case (s)
                S_STALL:  obs = {31'd0, stall};
                S_PC_EN:  obs = {31'd0, PC_en};
                S_FD_EN:  obs = {31'd0, FD_en};
                S_DE_CLR: obs = {31'd0, DE_clr};
                S_BUSY:   obs = {31'd0, md_busy};
                S_DONE:   obs = {31'd0, md_done};
                S_DIVQ:   obs = {31'd0, md_div_q};
                default:  obs = stall_cnt;
            endcase
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_rs_use = 1'b0; D_rt_use = 1'b0;
        D_rs_tuse = 2'd0; D_rt_tuse = 2'd0; D_is_md = 1'b0;
        E_A3 = 5'd0; E_we = 1'b0; E_tnew = 2'd0;
        M_A3 = 5'd0; M_we = 1'b0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    task automatic load_use_inputs();
        idle_inputs();
        D_rs = 5'd5; D_rs_use = 1'b1; D_rs_tuse = 2'd1;
        E_we = 1'b1; E_A3 = 5'd5; E_tnew = 2'd2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        tick();

        // Reset state
        push_stall("reset", 1'b0);
        push_md("reset", 1'b0, 1'b0, 1'b0);
        push("reset.stall_cnt", S_CNT, 32'd0);
        drain();

        // Data hazards (combinational only)
        tick();
        load_use_inputs();
        push_stall("load_use", 1'b1);
        drain();
        E_tnew = 2'd1;
        push_stall("load_use_equal", 1'b0);
        drain();
        E_tnew = 2'd2; D_rs = 5'd0; E_A3 = 5'd0;
        push_stall("zero_reg", 1'b0);
        drain();
        idle_inputs();
        M_we = 1'b1; M_A3 = 5'd9; M_tnew = 2'd1;
        D_rt = 5'd9; D_rt_use = 1'b1; D_rt_tuse = 2'd0;
        push_stall("m_rt", 1'b1);
        drain();
        D_rt_use = 1'b0;
        push_stall("m_rt_unused", 1'b0);
        drain();
        tick();
        D_rt_use = 1'b1; M_A3 = 5'd8;
        push_stall("m_rt_other_reg", 1'b0);
        drain();
        M_A3 = 5'd9; M_tnew = 2'd0;
        push_stall("m_rt_ready", 1'b0);
        drain();

        // Mult sequence
        idle_inputs();
        do_reset();
        E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
        push_stall("mult_start", 1'b1);
        push_md("mult_start", 1'b0, 1'b0, 1'b0);
        drain();
        tick();
        E_md_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_stall($sformatf("mult_c%0d", k), 1'b1);
            push_md($sformatf("mult_c%0d", k), 1'b1, k == 5, 1'b0);
            drain();
            tick();
        end
        push_stall("mult_after", 1'b0);
        push_md("mult_after", 1'b0, 1'b0, 1'b0);
        push("mult_after.stall_cnt", S_CNT, 32'd6);
        drain();
        D_is_md = 1'b0;
        push_stall("mult_after_nomd", 1'b0);
        drain();

        // Div followed back-to-back by mult; a stray start mid-div is ignored
        tick();
        E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            E_md_start = (k == 3) || (k == 10);
            E_md_div   = 1'b0;
            push_md($sformatf("b2b_c%0d", k), 1'b1, (k == 10) || (k == 15), k <= 10);
            drain();
            tick();
        end
        E_md_start = 1'b0;
        push_md("b2b_after", 1'b0, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a divide
        E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        E_md_start = 1'b0; E_md_div = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push_md($sformatf("rst_div_c%0d", k), 1'b1, 1'b0, 1'b1);
            drain();
            if (k < 4) tick();
        end
        do_reset();
        push_md("rst_div_post", 1'b0, 1'b0, 1'b0);
        push("rst_div_post.stall_cnt", S_CNT, 32'd0);
        drain();
        for (int k = 0; k < 12; k++) begin
            tick();
            push_md($sformatf("rst_div_idle%0d", k), 1'b0, 1'b0, 1'b0);
            drain();
        end

        // Stall counter over a 7-cycle data hazard
        load_use_inputs();
        for (int k = 0; k < 7; k++) tick();
        idle_inputs();
        push("stall_cnt_7", S_CNT, 32'd7);
        drain();

        // Saturation: preload close to the top and keep stalling
        load_use_inputs();
        force dut.stall_cnt = 32'hFFFF_FFFD;
        tick();
        release dut.stall_cnt;
        for (int k = 0; k < 4; k++) tick();
        push("stall_cnt_sat", S_CNT, 32'hFFFF_FFFF);
        drain();
        for (int k = 0; k < 3; k++) tick();
        push("stall_cnt_sat_hold", S_CNT, 32'hFFFF_FFFF);
        drain();
        idle_inputs();
        do_reset();
        push("stall_cnt_cleared", S_CNT, 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_hazard_ctrl.md
Name: md_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline; it is also the sequencer for the multiply/divide unit (MDU).
- Compares decoded register demand (Tuse) in D against supply (Tnew) in E/M and generates freeze/bubble controls for PC, F/D register and D/E register.
- Owns the MDU busy state machine: launches mult/div from E, counts latency, pulses completion, and stalls HI/LO-touching instructions in D while the MDU is occupied.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- D_rs  in  5  rs index of instruction in D
- D_rt  in  5  rt index of instruction in D
- D_rs_use  in  1  D instruction reads rs
- D_rt_use  in  1  D instruction reads rt
- D_rs_tuse  in  2  cycles until rs is needed (0 = in D)
- D_rt_tuse  in  2  cycles until rt is needed
- D_is_md  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register of E instruction
- E_we  in  1  E instruction writes GPR
- E_tnew  in  2  cycles until E result is available (0..2)
- M_A3  in  5  destination register of M instruction
- M_we  in  1  M instruction writes GPR
- M_tnew  in  2  cycles until M result is available (0..1)
- E_md_start  in  1  E instruction is mult/multu/div/divu
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  combinational stall request
- PC_en  out  1  ~stall
- FD_en  out  1  ~stall
- DE_clr  out  1  stall; DE register loads NOP and reset values
- md_busy  out  1  registered; MDU occupied
- md_done  out  1  registered; one-cycle pulse in the last busy cycle (HI/LO write)
- md_div_q  out  1  registered; latched op type of the running operation
- stall_cnt  out  32  registered; saturating count of stall cycles

Behaviour:
- Reset, synchronous: FSM=IDLE, cnt=0, md_busy=0, md_done=0, md_div_q=0, stall_cnt=0. Reset mid-operation aborts the MDU operation with no md_done pulse.
- Data stall on rs: D_rs_use && D_rs!=0 && ((E_we && E_A3==D_rs && D_rs_tuse<E_tnew) || (M_we && M_A3==D_rs && D_rs_tuse<M_tnew)). The rt rule is the same, using the rt signals.
- Register 0 never causes a stall. Equal Tuse/Tnew does not stall; forwarding covers it.
- MD stall: D_is_md && (E_md_start || md_busy).
- stall = data stall || MD stall. Purely combinational, with no added cycle. PC_en/FD_en/DE_clr are derived directly from stall.
- FSM IDLE: on E_md_start, go to BUSY. Set cnt = DIV_CYCLES or MULT_CYCLES per E_md_div, md_div_q=E_md_div, md_busy=1.
- FSM BUSY: cnt decrements each cycle. md_done=1 in the cycle cnt==1. On the next edge return to IDLE with md_busy=0.
- Timing: start sampled at edge t. md_busy is high for exactly N cycles, t+1..t+N. md_done is high only in cycle t+N.
- E_md_start while BUSY cannot occur legally, because the MD stall blocks it. If it is asserted anyway, it is ignored and the current count continues.
- Back-to-back: start may be accepted in the same edge that leaves BUSY, when md_done=1 and E_md_start=1. The FSM reloads and stays BUSY, with no idle gap.
- stall_cnt increments on every edge where stall=1. It saturates at 32'hFFFFFFFF.

Test Plan:
- Load-use: E_we=1, E_A3=5, E_tnew=2, D_rs=5, D_rs_use=1, D_rs_tuse=1 -> stall=1, DE_clr=1, PC_en=0. With E_tnew=1 -> stall=0.
- Zero register: same as above but D_rs=0 and E_A3=0 -> stall=0. M-stage case M_tnew=1, D_rt_tuse=0, match on rt=9 -> stall=1.
- Mult sequence: E_md_start=1, E_md_div=0 for one cycle -> md_busy high exactly 5 cycles, md_done high only in the 5th, md_div_q=0. D_is_md=1 is stalled during the start cycle plus all 5 busy cycles; D_is_md=0 with no data hazard -> stall=0.
- Div back-to-back: div start, then new start (div=0) in the md_done cycle -> md_busy stays high 10+5 consecutive cycles, md_done pulses at cycles 10 and 15.
- Reset mid-div: reset at busy cycle 4 -> next cycle md_busy=0, md_done never pulses, stall_cnt=0.
- Stall counter: hold a data hazard for 7 cycles -> stall_cnt=7. Preloading near saturation through a long stall holds the count at 32'hFFFFFFFF.
